clk_phase_gen: RTL and testbench

Parametrised multi-phase clock-enable generator and successor to the two-phase gated-clock generator. It produces NUM_PHASES rotating, non-overlapping phase enables from a single clock. Each phase has a programmable width, and an optional programmable dead time separates phases. Downstream logic uses the enables as `if (phase_en[k])` qualifiers on `clk`. The clock itself is never gated, so the block stays safe for synthesis and STA.

---
 rtl/clk_phase_gen_pkg.sv | 18 +
 rtl/clk_phase_gen_if.sv | 28 ++
 rtl/clk_phase_cnt.sv | 35 +++
 rtl/clk_phase_gen.sv | 154 +++++++++++++++
 tb/tb_clk_phase_gen.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/clk_phase_gen_pkg.sv
// rtl/clk_phase_gen_pkg.sv - shared types and constants for the multi-phase clock-enable generator
package clk_phase_gen_pkg;

  localparam int MIN_PHASES = 2;
  localparam int MAX_PHASES = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // $clog2 with a floor of one bit so single-bit index fields stay legal
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_phase_gen_if.sv
// rtl/clk_phase_gen_if.sv - run-control and phase-output bundle between a controller and the generator
interface clk_phase_gen_if
  import clk_phase_gen_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int DIV_W      = 8
);
  localparam int IDX_W = idx_width(NUM_PHASES);

  logic                  enable;
  logic [DIV_W-1:0]      div;
  logic [DIV_W-1:0]      gap;
  logic [NUM_PHASES-1:0] phase_en;
  logic [IDX_W-1:0]      phase_idx;
  logic                  cycle_start;
  logic                  busy;

  modport master (
    output enable, div, gap,
    input  phase_en, phase_idx, cycle_start, busy
  );

  modport slave (
    input  enable, div, gap,
    output phase_en, phase_idx, cycle_start, busy
  );

endinterface

// File: rtl/clk_phase_cnt.sv
// rtl/clk_phase_cnt.sv - loadable down-counter timing both phase width and dead time
module clk_phase_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_phase_gen.sv
// rtl/clk_phase_gen.sv - rotating non-overlapping phase-enable generator; dead time under CLK_PHASE_GEN_GAP_EN
module clk_phase_gen
  import clk_phase_gen_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int DIV_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  clk_phase_gen_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_PHASES);

  if ((NUM_PHASES < MIN_PHASES) || (NUM_PHASES > MAX_PHASES)) begin : g_bad_phases
    $error("clk_phase_gen: NUM_PHASES out of range");
  end

  state_e                state_q;
  logic [NUM_PHASES-1:0] phase_en_q;
  logic [IDX_W-1:0]      phase_idx_q;
  logic                  cycle_start_q;
  logic                  busy_q;

  logic [IDX_W-1:0]      next_idx;
  logic [DIV_W-1:0]      gap_eff;
  logic                  cnt_zero;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic [DIV_W-1:0]      cnt_load_val;

`ifdef CLK_PHASE_GEN_GAP_EN
  assign gap_eff = bus.gap;
`else
  assign gap_eff = '0;
`endif

  assign next_idx = (phase_idx_q == IDX_W'(NUM_PHASES - 1)) ? '0 : phase_idx_q + IDX_W'(1);

  // Counter holds the cycles remaining in the current phase or gap; zero marks the boundary
  always_comb begin
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = bus.div;
    case (state_q)
      ST_IDLE: begin
        cnt_load = bus.enable;
      end
      ST_ACTIVE: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (bus.enable) begin
          cnt_load = 1'b1;
          if (gap_eff != '0) begin
            cnt_load_val = gap_eff - DIV_W'(1);
          end
        end
      end
`ifdef CLK_PHASE_GEN_GAP_EN
      ST_GAP: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          cnt_load = bus.enable;
        end
      end
`endif
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  clk_phase_cnt #(
    .DIV_W(DIV_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_en_q    <= '0;
      phase_idx_q   <= '0;
      cycle_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      cycle_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.enable) begin
            state_q       <= ST_ACTIVE;
            phase_idx_q   <= '0;
            phase_en_q    <= NUM_PHASES'(1);
            cycle_start_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (cnt_zero) begin
            // A stop request is honoured only here, so a phase is never cut short
            if (!bus.enable) begin
              state_q    <= ST_IDLE;
              phase_en_q <= '0;
              busy_q     <= 1'b0;
            end
`ifdef CLK_PHASE_GEN_GAP_EN
            else if (gap_eff != '0) begin
              state_q    <= ST_GAP;
              phase_en_q <= '0;
            end
`endif
            else begin
              phase_idx_q   <= next_idx;
              phase_en_q    <= NUM_PHASES'(1) << next_idx;
              cycle_start_q <= (next_idx == '0);
            end
          end
        end
`ifdef CLK_PHASE_GEN_GAP_EN
        ST_GAP: begin
          if (cnt_zero) begin
            if (!bus.enable) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q       <= ST_ACTIVE;
              phase_idx_q   <= next_idx;
              phase_en_q    <= NUM_PHASES'(1) << next_idx;
              cycle_start_q <= (next_idx == '0);
            end
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          phase_en_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase_en    = phase_en_q;
  assign bus.phase_idx   = phase_idx_q;
  assign bus.cycle_start = cycle_start_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_clk_phase_gen.sv
// tb/tb_clk_phase_gen.sv - directed self-checking bench for clk_phase_gen with 4-phase and 2-phase instances
module tb_clk_phase_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef CLK_PHASE_GEN_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  clk_phase_gen_if #(.NUM_PHASES(4), .DIV_W(8)) a_if ();
  clk_phase_gen_if #(.NUM_PHASES(2), .DIV_W(8)) b_if ();

  clk_phase_gen #(.NUM_PHASES(4), .DIV_W(8)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (a_if)
  );

  clk_phase_gen #(.NUM_PHASES(2), .DIV_W(8)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected 4-phase outputs c cycles after start, for phase width dv+1 and gap g
  function automatic logic [3:0] exp_en4(input int c, input int dv, input int g);
    logic [3:0] e;
    int p, k, off;
    p   = dv + 1 + g;
    k   = (c / p) % 4;
    off = c % p;
    e   = '0;
    if (off <= dv) e[k] = 1'b1;
    return e;
  endfunction

  function automatic logic [1:0] exp_idx4(input int c, input int dv, input int g);
    return 2'((c / (dv + 1 + g)) % 4);
  endfunction

  function automatic logic exp_cs4(input int c, input int dv, input int g);
    return ((c % (4 * (dv + 1 + g))) == 0);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if (a_if.phase_en !== 4'b0000) begin n_fail++; $display("FAIL reset_a_en got %b exp 0000", a_if.phase_en); end
    n_checks++; if (a_if.phase_idx !== 2'd0) begin n_fail++; $display("FAIL reset_a_idx got %0d exp 0", a_if.phase_idx); end
    n_checks++; if (a_if.cycle_start !== 1'b0) begin n_fail++; $display("FAIL reset_a_cs got %b exp 0", a_if.cycle_start); end
    n_checks++; if (a_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_a_busy got %b exp 0", a_if.busy); end
    n_checks++; if (b_if.phase_en !== 2'b00 || b_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_b got en=%b busy=%b exp 00/0", b_if.phase_en, b_if.busy); end
    rst_n = 1'b1;
    step();
    n_checks++; if (a_if.busy !== 1'b0 || a_if.phase_en !== 4'b0000) begin n_fail++; $display("FAIL idle_hold got en=%b busy=%b exp 0000/0", a_if.phase_en, a_if.busy); end
  endtask

  task automatic test_two_phase();
    b_if.div    = 8'd0;
    b_if.gap    = 8'd0;
    b_if.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (b_if.phase_en !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL two_phase_en c=%0d got %b exp %b", i, b_if.phase_en, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      n_checks++;
      if (b_if.cycle_start !== (i % 2 == 0) || b_if.busy !== 1'b1) begin
        n_fail++; $display("FAIL two_phase_cs c=%0d got cs=%b busy=%b exp cs=%b busy=1", i, b_if.cycle_start, b_if.busy, i % 2 == 0);
      end
    end
    b_if.enable = 1'b0;
    step();
    n_checks++; if (b_if.phase_en !== 2'b00 || b_if.busy !== 1'b0) begin n_fail++; $display("FAIL two_phase_stop got en=%b busy=%b exp 00/0", b_if.phase_en, b_if.busy); end
  endtask

  task automatic test_gap();
    int g, total;
    g = GAP_ON ? 1 : 0;
    total = 2 * 4 * (3 + g);
    a_if.div    = 8'd2;
    a_if.gap    = 8'd1;
    a_if.enable = 1'b1;
    for (int c = 0; c < total; c++) begin
      step();
      n_checks++;
      if (a_if.phase_en !== exp_en4(c, 2, g) || a_if.phase_idx !== exp_idx4(c, 2, g)) begin
        n_fail++; $display("FAIL gap_seq c=%0d got en=%b idx=%0d exp en=%b idx=%0d", c, a_if.phase_en, a_if.phase_idx, exp_en4(c, 2, g), exp_idx4(c, 2, g));
      end
      n_checks++;
      if (a_if.cycle_start !== exp_cs4(c, 2, g) || a_if.busy !== 1'b1) begin
        n_fail++; $display("FAIL gap_cs c=%0d got cs=%b busy=%b exp cs=%b busy=1", c, a_if.cycle_start, a_if.busy, exp_cs4(c, 2, g));
      end
    end
    a_if.enable = 1'b0;
    step();
    n_checks++; if (a_if.phase_en !== 4'b0000 || a_if.busy !== 1'b0) begin n_fail++; $display("FAIL gap_stop got en=%b busy=%b exp 0000/0", a_if.phase_en, a_if.busy); end
  endtask

  task automatic test_div_change();
    logic [3:0] e;
    a_if.div    = 8'd2;
    a_if.gap    = 8'd0;
    a_if.enable = 1'b1;
    for (int c = 0; c < 13; c++) begin
      step();
      e = (c < 3) ? 4'b0001 : (c < 6) ? 4'b0010 : (c < 12) ? 4'b0100 : 4'b1000;
      n_checks++;
      if (a_if.phase_en !== e) begin n_fail++; $display("FAIL div_change c=%0d got %b exp %b", c, a_if.phase_en, e); end
      if (c == 3) a_if.div = 8'd5;
    end
    a_if.enable = 1'b0;
    for (int c = 13; c < 18; c++) begin
      step();
      n_checks++;
      if (a_if.phase_en !== 4'b1000 || a_if.busy !== 1'b1) begin n_fail++; $display("FAIL div_change_tail c=%0d got en=%b busy=%b exp 1000/1", c, a_if.phase_en, a_if.busy); end
    end
    step();
    n_checks++; if (a_if.phase_en !== 4'b0000 || a_if.busy !== 1'b0) begin n_fail++; $display("FAIL div_change_stop got en=%b busy=%b exp 0000/0", a_if.phase_en, a_if.busy); end
  endtask

  task automatic test_stop();
    a_if.div    = 8'd3;
    a_if.gap    = 8'd0;
    a_if.enable = 1'b1;
    step();
    n_checks++; if (a_if.phase_en !== 4'b0001 || a_if.cycle_start !== 1'b1) begin n_fail++; $display("FAIL stop_start got en=%b cs=%b exp 0001/1", a_if.phase_en, a_if.cycle_start); end
    step();
    a_if.enable = 1'b0;
    for (int c = 2; c < 4; c++) begin
      step();
      n_checks++;
      if (a_if.phase_en !== 4'b0001 || a_if.busy !== 1'b1) begin n_fail++; $display("FAIL stop_no_trunc c=%0d got en=%b busy=%b exp 0001/1", c, a_if.phase_en, a_if.busy); end
    end
    step();
    n_checks++; if (a_if.phase_en !== 4'b0000 || a_if.busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle got en=%b busy=%b exp 0000/0", a_if.phase_en, a_if.busy); end
    step();
    n_checks++; if (a_if.busy !== 1'b0 || a_if.phase_idx !== 2'd0) begin n_fail++; $display("FAIL stop_hold got busy=%b idx=%0d exp 0/0", a_if.busy, a_if.phase_idx); end
    a_if.enable = 1'b1;
    step();
    n_checks++; if (a_if.phase_en !== 4'b0001 || a_if.cycle_start !== 1'b1 || a_if.busy !== 1'b1) begin n_fail++; $display("FAIL stop_restart got en=%b cs=%b busy=%b exp 0001/1/1", a_if.phase_en, a_if.cycle_start, a_if.busy); end
    a_if.enable = 1'b0;
    repeat (4) step();
    n_checks++; if (a_if.busy !== 1'b0) begin n_fail++; $display("FAIL stop_restart_end got busy=%b exp 0", a_if.busy); end
  endtask

  task automatic test_reset_mid();
    a_if.div    = 8'd2;
    a_if.gap    = 8'd0;
    a_if.enable = 1'b1;
    for (int c = 0; c < 8; c++) step();
    n_checks++; if (a_if.phase_en !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_pre got %b exp 0100", a_if.phase_en); end
    rst_n = 1'b0;
    step();
    n_checks++;
    if (a_if.phase_en !== 4'b0000 || a_if.phase_idx !== 2'd0 || a_if.cycle_start !== 1'b0 || a_if.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_clear got en=%b idx=%0d cs=%b busy=%b exp all 0", a_if.phase_en, a_if.phase_idx, a_if.cycle_start, a_if.busy);
    end
    rst_n = 1'b1;
    step();
    n_checks++; if (a_if.phase_en !== 4'b0001 || a_if.cycle_start !== 1'b1 || a_if.busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_restart got en=%b cs=%b busy=%b exp 0001/1/1", a_if.phase_en, a_if.cycle_start, a_if.busy); end
    a_if.enable = 1'b0;
    repeat (3) step();
    n_checks++; if (a_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_end got busy=%b exp 0", a_if.busy); end
  endtask

  task automatic test_gap_ignored();
    int g, total;
    g = GAP_ON ? 7 : 0;
    total = 2 * 4 * (2 + g);
    a_if.div    = 8'd1;
    a_if.gap    = 8'd7;
    a_if.enable = 1'b1;
    for (int c = 0; c < total; c++) begin
      step();
      n_checks++;
      if (a_if.phase_en !== exp_en4(c, 1, g) || a_if.cycle_start !== exp_cs4(c, 1, g)) begin
        n_fail++; $display("FAIL gap7_seq c=%0d got en=%b cs=%b exp en=%b cs=%b", c, a_if.phase_en, a_if.cycle_start, exp_en4(c, 1, g), exp_cs4(c, 1, g));
      end
    end
    a_if.enable = 1'b0;
    step();
    n_checks++; if (a_if.busy !== 1'b0 || a_if.phase_en !== 4'b0000) begin n_fail++; $display("FAIL gap7_stop got en=%b busy=%b exp 0000/0", a_if.phase_en, a_if.busy); end
  endtask

  initial begin
    a_if.enable = 1'b0;
    a_if.div    = 8'd0;
    a_if.gap    = 8'd0;
    b_if.enable = 1'b0;
    b_if.div    = 8'd0;
    b_if.gap    = 8'd0;
    test_reset();
    test_two_phase();
    test_gap();
    test_div_change();
    test_stop();
    test_reset_mid();
    test_gap_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
